// File: rtl/gf256_syndrome_seq.sv
// gf256_syndrome_seq: Reed-Solomon syndrome accumulator over GF(256) using one shared multiplier
// Horner update S_j <= S_j*alpha^j ^ r, one syndrome per cycle, N_SYN cycles per received byte.
module gf256_syndrome_seq #(
   parameter int N_BYTES = 32,
   parameter int N_SYN   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [7:0]         mult_a,
   output logic [7:0]         mult_b,
   input  logic [7:0]         mult_x,
   output logic [8*N_SYN-1:0] syn_out,
   output logic               syn_zero,
   output logic               syn_valid,
   input  logic               syn_ready
);
   localparam logic [1:0] READY = 2'd0;
   localparam logic [1:0] MUL   = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   logic [1:0]         state;
   logic [2:0]         j;
   logic [7:0]         byte_cnt;
   logic [7:0]         r_reg;
   logic [8*N_SYN-1:0] s;
   logic               last_syn;
   logic               last_byte;
   assign last_syn  = j == 3'(N_SYN - 1);
   assign last_byte = byte_cnt == 8'(N_BYTES - 1);
   assign in_ready  = state == READY;
   assign syn_valid = state == DONE;
   assign mult_a    = state == MUL ? s[8*j +: 8] : 8'h00;
   assign mult_b    = state == MUL ? 8'h01 << j : 8'h00;
   assign syn_out   = s;
   assign syn_zero  = ~|s;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= READY;
         j        <= '0;
         byte_cnt <= '0;
         r_reg    <= '0;
         s        <= '0;
      end else if (clear) begin
         state    <= READY;
         j        <= '0;
         byte_cnt <= '0;
         s        <= '0;
      end else
         case (state)
            READY:
               if (in_valid) begin
                  r_reg <= in_data;
                  j     <= '0;
                  state <= MUL;
               end
            MUL: begin
               s[8*j +: 8] <= mult_x ^ r_reg;
               j           <= last_syn ? 3'd0 : j + 3'd1;
               if (last_syn) begin
                  state    <= last_byte ? DONE : READY;
                  byte_cnt <= last_byte ? 8'd0 : byte_cnt + 8'd1;
               end
            end
            DONE:
               if (syn_ready) begin
                  s     <= '0;
                  state <= READY;
               end
            default: state <= READY;
         endcase
endmodule

// File: tb/tb_gf256_syndrome_seq.sv
// tb_gf256_syndrome_seq: scoreboard bench driving a 32-byte and a 2-byte syndrome block
// through one shared stimulus port selected by sel; expected syndromes come from a direct sum.
module tb_gf256_syndrome_seq;
   logic        clk = 0;
   logic        rst_n = 1;
   logic        clear = 0;
   logic        in_valid = 0;
   logic        syn_ready = 1;
   logic        sel = 0;
   logic [7:0]  in_data = 0;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  cw[$];
   logic        rdy_a, rdy_b, val_a, val_b, zero_a, zero_b;
   logic [7:0]  ma_a, mb_a, mx_a, ma_b, mb_b, mx_b;
   logic [31:0] syn_a, syn_b;
   logic        rdy, val, zero;
   logic [7:0]  ma, mb;
   logic [31:0] syn;

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      p = 0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = a[7] ? (a << 1) ^ 8'h1D : a << 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] gpow(int n);
      logic [7:0] r;
      r = 1;
      for (int i = 0; i < n % 255; i++) r = gmul(r, 8'h02);
      return r;
   endfunction

   assign mx_a = gmul(ma_a, mb_a);
   assign mx_b = gmul(ma_b, mb_b);
   assign rdy  = sel ? rdy_b : rdy_a;
   assign val  = sel ? val_b : val_a;
   assign zero = sel ? zero_b : zero_a;
   assign ma   = sel ? ma_b : ma_a;
   assign mb   = sel ? mb_b : mb_a;
   assign syn  = sel ? syn_b : syn_a;

   gf256_syndrome_seq #(.N_BYTES(32), .N_SYN(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data),
      .in_valid(in_valid & ~sel), .in_ready(rdy_a), .mult_a(ma_a), .mult_b(mb_a),
      .mult_x(mx_a), .syn_out(syn_a), .syn_zero(zero_a), .syn_valid(val_a),
      .syn_ready(syn_ready & ~sel));

   gf256_syndrome_seq #(.N_BYTES(2), .N_SYN(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data),
      .in_valid(in_valid & sel), .in_ready(rdy_b), .mult_a(ma_b), .mult_b(mb_b),
      .mult_x(mx_b), .syn_out(syn_b), .syn_zero(zero_b), .syn_valid(val_b),
      .syn_ready(syn_ready & sel));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // direct S_j = sum r_i*alpha^(i*j); the first byte of a codeword has the highest degree
   task automatic model_byte(input logic [7:0] b);
      int          nb;
      logic [31:0] e;
      logic [7:0]  acc;
      nb = sel ? 2 : 32;
      cw.push_back(b);
      if (cw.size() == nb) begin
         e = 0;
         for (int jj = 0; jj < 4; jj++) begin
            acc = 0;
            for (int k = 0; k < nb; k++) acc ^= gmul(cw[k], gpow(jj * (nb - 1 - k)));
            e[8*jj +: 8] = acc;
         end
         exp_q.push_back(e);
         cw.delete();
      end
   endtask

   task automatic send(input logic [7:0] b, output int w);
      w = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1;
      while (!rdy && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!rdy) check("accept_timeout", 0, 1);
      else begin
         @(posedge clk);
         #1 model_byte(b);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!val && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!val) check("valid_timeout", 0, 1);
   endtask

   always @(negedge clk)
      if (rst_n && !clear && val && syn_ready) begin
         if (exp_q.size() == 0) check("sb_empty", 0, 1);
         else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("syn", syn, e);
            check("syn_zero", 32'(zero), 32'(e == 0));
         end
      end

   initial begin
      int w, n;
      #1 rst_n = 0;
      #10 rst_n = 1;
      #2;
      check("rst_ready", 32'(rdy), 1);
      check("rst_valid", 32'(val), 0);
      check("rst_zero", 32'(zero), 1);
      check("rst_ma", 32'(ma), 0);
      check("rst_mb", 32'(mb), 0);
      check("rst_syn", syn, 0);
      // T1: all-zero 32-byte codeword and completion latency
      for (int i = 0; i < 32; i++) send(8'h00, w);
      in_valid = 0;
      wait_valid(n);
      check("t1_latency", n, 5);
      check("t1_zero", 32'(zero), 1);
      repeat (3) @(negedge clk);
      // T2: single impulse at the top degree
      sel = 1;
      send(8'h01, w);
      send(8'h00, w);
      in_valid = 0;
      wait_valid(n);
      check("t2_syn", syn, 32'h08040201);
      check("t2_zero", 32'(zero), 0);
      repeat (3) @(negedge clk);
      // T3: consumer stall holds the result and blocks input
      syn_ready = 0;
      send(8'h01, w);
      send(8'h01, w);
      in_valid = 0;
      wait_valid(n);
      in_data  = 8'hAA;
      in_valid = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_hold_syn", syn, 32'h09050300);
         check("t3_hold_rdy", 32'(rdy), 0);
         check("t3_hold_val", 32'(val), 1);
      end
      @(posedge clk);
      #1 in_valid = 0;
      syn_ready = 1;
      repeat (3) @(negedge clk);
      // T4: in_valid held high across four back-to-back codewords
      for (int i = 0; i < 8; i++) begin
         send(8'($urandom_range(0, 255)), w);
         if (i > 0) check(i % 2 ? "t4_gap" : "t4_gap_cw", w, i % 2 ? 4 : 5);
      end
      in_valid = 0;
      repeat (8) @(negedge clk);
      check("t4_drain", exp_q.size(), 0);
      // T5: abort a partial codeword with clear
      sel = 0;
      for (int i = 0; i < 10; i++) send(8'($urandom_range(1, 255)), w);
      in_valid = 0;
      @(negedge clk);
      clear = 1;
      @(posedge clk);
      #1 clear = 0;
      cw.delete();
      @(negedge clk);
      check("t5_syn", syn, 0);
      check("t5_rdy", 32'(rdy), 1);
      check("t5_val", 32'(val), 0);
      for (int i = 0; i < 32; i++) send(8'h00, w);
      in_valid = 0;
      wait_valid(n);
      check("t5_zero", 32'(zero), 1);
      repeat (3) @(negedge clk);
      // T6: asynchronous reset between clock edges while multiplying
      for (int i = 0; i < 3; i++) send(8'($urandom_range(1, 255)), w);
      in_valid = 0;
      #2 rst_n = 0;
      #1;
      check("t6_syn", syn, 0);
      check("t6_rdy", 32'(rdy), 1);
      check("t6_val", 32'(val), 0);
      check("t6_zero", 32'(zero), 1);
      check("t6_ma", 32'(ma), 0);
      check("t6_mb", 32'(mb), 0);
      #1 rst_n = 1;
      cw.delete();
      for (int i = 0; i < 32; i++) send(8'($urandom_range(0, 255)), w);
      in_valid = 0;
      wait_valid(n);
      repeat (4) @(negedge clk);
      check("t6_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
